// File: rtl/fp_div_round_norm.sv
// rtl/fp_div_round_norm.sv - FP divider output stage: normalize, round-to-nearest-even, pack IEEE-754 single
module fp_div_round_norm #(
    parameter int QW = 28,
    parameter int EW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    input  logic          in_sign,
    input  logic [EW-1:0] in_exp,
    input  logic [QW-1:0] in_mant,
    input  logic          in_sticky,
    input  logic          in_nan,
    input  logic          in_inf,
    input  logic          in_zero,
    output logic          out_valid,
    output logic [31:0]   C,
    output logic          ovf,
    output logic          unf,
    output logic          inexact
);

    localparam logic signed [EW+1:0] EXP_MAX = (EW+2)'(255);

    // Stage 1 next-state: leading one is implicit after normalization, so only bits below it are kept
    logic [QW-2:0]          norm_d;
    logic signed [EW:0]     exp1_d;
    logic [22:0]            frac1_d;
    logic                   g1_d;
    logic                   s1_d;
    logic                   nan1_d;
    logic                   inf1_d;
    logic                   zero1_d;

    logic                   v1_q;
    logic                   sign1_q;
    logic signed [EW:0]     exp1_q;
    logic [22:0]            frac1_q;
    logic                   g1_q;
    logic                   s1_q;
    logic                   nan1_q;
    logic                   inf1_q;
    logic                   zero1_q;

    always_comb begin
        if (in_mant[QW-1]) begin
            norm_d = in_mant[QW-2:0];
            exp1_d = {in_exp[EW-1], in_exp};
        end else begin
            norm_d = {in_mant[QW-3:0], 1'b0};
            exp1_d = {in_exp[EW-1], in_exp} - (EW+1)'(1);
        end
        frac1_d = norm_d[QW-2 -: 23];
        g1_d    = norm_d[QW-25];
        s1_d    = (|norm_d[QW-26:0]) | in_sticky;
        nan1_d  = in_nan;
        inf1_d  = in_inf & ~in_nan;
        zero1_d = in_zero & ~in_nan & ~in_inf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            exp1_q  <= '0;
            frac1_q <= '0;
            g1_q    <= 1'b0;
            s1_q    <= 1'b0;
            nan1_q  <= 1'b0;
            inf1_q  <= 1'b0;
            zero1_q <= 1'b0;
        end else if (en) begin
            v1_q <= in_valid;
            if (in_valid) begin
                sign1_q <= in_sign;
                exp1_q  <= exp1_d;
                frac1_q <= frac1_d;
                g1_q    <= g1_d;
                s1_q    <= s1_d;
                nan1_q  <= nan1_d;
                inf1_q  <= inf1_d;
                zero1_q <= zero1_d;
            end
        end
    end

    // Stage 2: a carry out of the 23-bit fraction means the mantissa rolled over to 1.0
    logic                   round_up;
    logic [23:0]            frac_rnd;
    logic signed [EW+1:0]   exp2;
    logic                   under;
    logic [31:0]            c_d;
    logic                   ovf_d;
    logic                   unf_d;
    logic                   inexact_d;

    logic                   out_valid_q;
    logic [31:0]            c_q;
    logic                   ovf_q;
    logic                   unf_q;
    logic                   inexact_q;

    always_comb begin
        round_up  = g1_q & (s1_q | frac1_q[0]);
        frac_rnd  = {1'b0, frac1_q} + 24'(round_up);
        exp2      = {exp1_q[EW], exp1_q} + (EW+2)'(frac_rnd[23]);
        under     = exp1_q[EW] | (exp1_q == '0);
        c_d       = {sign1_q, exp2[7:0], frac_rnd[22:0]};
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        inexact_d = g1_q | s1_q;
        if (nan1_q) begin
            c_d       = 32'h7FC0_0000;
            inexact_d = 1'b0;
        end else if (inf1_q) begin
            c_d       = {sign1_q, 8'hFF, 23'h0};
            inexact_d = 1'b0;
        end else if (zero1_q) begin
            c_d       = {sign1_q, 31'h0};
            inexact_d = 1'b0;
        end else if (exp2 >= EXP_MAX) begin
            c_d       = {sign1_q, 8'hFF, 23'h0};
            ovf_d     = 1'b1;
            inexact_d = 1'b1;
        end else if (under) begin
            c_d       = {sign1_q, 31'h0};
            unf_d     = 1'b1;
            inexact_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inexact_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                c_q       <= c_d;
                ovf_q     <= ovf_d;
                unf_q     <= unf_d;
                inexact_q <= inexact_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign C         = c_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign inexact   = inexact_q;

endmodule
